// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register-index typedefs, the EX/MEM
// pipeline payload record and the EX/MEM control state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  localparam word_t RESET_EPC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    TRAP   = 2'd1,
    HALTED = 2'd2
  } exmem_state_t;

  // Everything the MEM stage sees from the EX/MEM boundary register.
  typedef struct packed {
    logic     valid;
    word_t    pc;
    word_t    alu_out;
    logic     zero;
    logic     neg;
    word_t    store_data;
    regbits_t rd;
    logic     reg_wen;
    logic     dmem_ren;
    logic     dmem_wen;
    logic     halt;
  } exmem_t;

  localparam exmem_t EXMEM_BUBBLE = '0;

endpackage

// File: rtl/ex_mem_if.sv
// EX/MEM boundary bundle. Modports are named for the pipeline side each
// half faces; directions are as seen by the ex_mem_reg boundary register.
interface ex_mem_if;
  import cpu_types_pkg::*;

  logic     ex_valid;
  word_t    ex_pc;
  word_t    alu_out;
  logic     alu_zero;
  logic     alu_neg;
  logic     alu_over;
  logic     check_over;
  word_t    store_data;
  regbits_t rd_addr;
  logic     reg_wen;
  logic     dmem_ren;
  logic     dmem_wen;
  logic     halt;

  logic     mem_valid;
  logic     mem_reg_wen;
  logic     mem_dmem_ren;
  logic     mem_dmem_wen;
  logic     mem_halt;
  logic     mem_zero;
  logic     mem_neg;
  word_t    mem_pc;
  word_t    mem_alu_out;
  word_t    mem_store_data;
  regbits_t mem_rd;

  modport ex (
    input ex_valid, ex_pc, alu_out, alu_zero, alu_neg, alu_over, check_over,
          store_data, rd_addr, reg_wen, dmem_ren, dmem_wen, halt
  );

  modport mem (
    output mem_valid, mem_reg_wen, mem_dmem_ren, mem_dmem_wen, mem_halt,
           mem_zero, mem_neg, mem_pc, mem_alu_out, mem_store_data, mem_rd
  );

endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with overflow-trap and halt tracking.
// Define OVERFLOW_TRAP_EN to enable signed-overflow traps (TRAP state, epc, exc_flush).
module ex_mem_reg
  import cpu_types_pkg::*;
#(
  parameter word_t RESET_EPC = RESET_EPC_DEFAULT
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  en,
  input  logic  flush,
  input  logic  exc_ack,
  ex_mem_if.ex  ex,
  ex_mem_if.mem mem,
  output logic  exc_flush,
  output logic  exc_pending,
  output word_t epc,
  output logic  halted
);

  exmem_state_t state, next_state;
  exmem_t       mem_q, capture;
  logic         trap_hit;
  logic         halt_hit;

`ifdef OVERFLOW_TRAP_EN
  assign trap_hit = (state == RUN) && !flush && ex.ex_valid && ex.check_over && ex.alu_over;
`else
  logic unused_ovf;
  assign unused_ovf = ex.check_over ^ ex.alu_over;
  assign trap_hit   = 1'b0;
`endif

  // A trapping instruction never commits its halt.
  assign halt_hit = (state == RUN) && !flush && !trap_hit && ex.ex_valid && ex.halt;

  // Payload to load on the next en-qualified edge.
  always_comb begin
    // NOTE: default first so every path assigns capture and no latch is inferred.
    capture = EXMEM_BUBBLE;
    if (state == RUN && !flush) begin
      capture.valid      = ex.ex_valid;
      capture.pc         = ex.ex_pc;
      capture.alu_out    = ex.alu_out;
      capture.zero       = ex.alu_zero;
      capture.neg        = ex.alu_neg;
      capture.store_data = ex.store_data;
      capture.rd         = ex.rd_addr;
      capture.reg_wen    = ex.reg_wen  & ex.ex_valid;
      capture.dmem_ren   = ex.dmem_ren & ex.ex_valid;
      capture.dmem_wen   = ex.dmem_wen & ex.ex_valid;
      capture.halt       = ex.halt     & ex.ex_valid;
      if (trap_hit) begin
        capture.reg_wen  = 1'b0;
        capture.dmem_ren = 1'b0;
        capture.dmem_wen = 1'b0;
        capture.halt     = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!nRST) begin
      mem_q <= EXMEM_BUBBLE;
    end else if (en) begin
      mem_q <= capture;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Leaving TRAP follows the front-end acknowledge, not the MEM-stage stall.
  always_comb begin
    next_state = state;
    unique case (state)
      RUN: begin
        if (en) begin
          if (trap_hit)      next_state = TRAP;
          else if (halt_hit) next_state = HALTED;
        end
      end
      TRAP: begin
        if (exc_ack) next_state = RUN;
      end
      HALTED: next_state = HALTED;
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    halted = (state == HALTED);
`ifdef OVERFLOW_TRAP_EN
    exc_pending = (state == TRAP);
`else
    exc_pending = 1'b0;
`endif
  end

`ifdef OVERFLOW_TRAP_EN
  // exc_flush is a single-cycle pulse even when the stage stalls afterwards.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      exc_flush <= 1'b0;
      epc       <= RESET_EPC;
    end else begin
      exc_flush <= en && trap_hit;
      if (en && trap_hit) begin
        epc <= ex.ex_pc;
      end
    end
  end
`else
  assign exc_flush = 1'b0;
  assign epc       = RESET_EPC;
`endif

  assign mem.mem_valid      = mem_q.valid;
  assign mem.mem_pc         = mem_q.pc;
  assign mem.mem_alu_out    = mem_q.alu_out;
  assign mem.mem_zero       = mem_q.zero;
  assign mem.mem_neg        = mem_q.neg;
  assign mem.mem_store_data = mem_q.store_data;
  assign mem.mem_rd         = mem_q.rd;
  assign mem.mem_reg_wen    = mem_q.reg_wen;
  assign mem.mem_dmem_ren   = mem_q.dmem_ren;
  assign mem.mem_dmem_wen   = mem_q.dmem_wen;
  assign mem.mem_halt       = mem_q.halt;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: the driver queues hand-computed expectations,
// a monitor pops and compares one entry after each clock edge that has one.
module tb_ex_mem_reg;
  import cpu_types_pkg::*;

  localparam word_t TB_RESET_EPC = 32'h0000_0100;
`ifdef OVERFLOW_TRAP_EN
  localparam word_t EPC_AFTER = 32'h0000_0040;
`else
  localparam word_t EPC_AFTER = TB_RESET_EPC;
`endif

  typedef struct packed {
    logic     en;
    logic     flush;
    logic     exc_ack;
    logic     valid;
    word_t    pc;
    word_t    alu;
    logic     zero;
    logic     neg;
    logic     over;
    logic     chk;
    word_t    sd;
    regbits_t rd;
    logic     reg_wen;
    logic     ren;
    logic     wen;
    logic     halt;
  } vec_t;

  typedef struct packed {
    logic  exc_flush;
    logic  exc_pending;
    logic  halted;
    word_t epc;
  } stat_t;

  typedef struct packed {
    exmem_t pipe;
    stat_t  stat;
  } exp_t;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  en, flush, exc_ack;
  logic  exc_flush, exc_pending, halted;
  word_t epc;

  ex_mem_if bus ();

  ex_mem_reg #(.RESET_EPC(TB_RESET_EPC)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .en          (en),
    .flush       (flush),
    .exc_ack     (exc_ack),
    .ex          (bus.ex),
    .mem         (bus.mem),
    .exc_flush   (exc_flush),
    .exc_pending (exc_pending),
    .epc         (epc),
    .halted      (halted)
  );

  always #5 CLK = ~CLK;

  exmem_t dut_pipe;
  stat_t  dut_stat;
  assign dut_pipe = {bus.mem_valid, bus.mem_pc, bus.mem_alu_out, bus.mem_zero, bus.mem_neg,
                     bus.mem_store_data, bus.mem_rd, bus.mem_reg_wen, bus.mem_dmem_ren,
                     bus.mem_dmem_wen, bus.mem_halt};
  assign dut_stat = {exc_flush, exc_pending, halted, epc};

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   id_q[$];
  int   vec_id   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic vec_t instr(word_t pc, word_t alu, regbits_t rd, logic reg_wen);
    vec_t v;
    v = '0;
    v.en = 1'b1; v.valid = 1'b1; v.pc = pc; v.alu = alu; v.rd = rd; v.reg_wen = reg_wen;
    return v;
  endfunction

  function automatic exmem_t mk_pipe(logic valid, word_t pc, word_t alu, regbits_t rd, logic reg_wen);
    exmem_t p;
    p = '0;
    p.valid = valid; p.pc = pc; p.alu_out = alu; p.rd = rd; p.reg_wen = reg_wen;
    return p;
  endfunction

  function automatic stat_t mk_st(logic f, logic p, logic h, word_t e);
    stat_t s;
    s.exc_flush = f; s.exc_pending = p; s.halted = h; s.epc = e;
    return s;
  endfunction

  task automatic drive(input vec_t v, input exmem_t ep, input stat_t es);
    @(negedge CLK);
    en = v.en; flush = v.flush; exc_ack = v.exc_ack;
    bus.ex_valid = v.valid;  bus.ex_pc = v.pc;        bus.alu_out = v.alu;
    bus.alu_zero = v.zero;   bus.alu_neg = v.neg;     bus.alu_over = v.over;
    bus.check_over = v.chk;  bus.store_data = v.sd;   bus.rd_addr = v.rd;
    bus.reg_wen = v.reg_wen; bus.dmem_ren = v.ren;    bus.dmem_wen = v.wen;
    bus.halt = v.halt;
    vec_id++;
    exp_q.push_back({ep, es});
    id_q.push_back(vec_id);
  endtask

  // Asynchronous reset asserted away from any clock edge.
  task automatic reset_pulse(input string tag);
    @(negedge CLK);
    en = 1'b0; flush = 1'b0; exc_ack = 1'b0;
    nRST = 1'b0;
    #1;
    check({tag, " pipe"}, dut_pipe, EXMEM_BUBBLE);
    check({tag, " status"}, dut_stat, mk_st(1'b0, 1'b0, 1'b0, TB_RESET_EPC));
    #2 nRST = 1'b1;
  endtask

  always @(posedge CLK) begin
    #1;
    if (exp_q.size() != 0) begin
      exp_t e;
      int   id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      check($sformatf("v%0d pipe", id), dut_pipe, e.pipe);
      check($sformatf("v%0d status", id), dut_stat, e.stat);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   v;
    exmem_t ep, p1, p8;
    stat_t  st0;

    nRST = 1'b0; en = 1'b0; flush = 1'b0; exc_ack = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_pc = '0; bus.alu_out = '0; bus.alu_zero = 1'b0;
    bus.alu_neg = 1'b0; bus.alu_over = 1'b0; bus.check_over = 1'b0; bus.store_data = '0;
    bus.rd_addr = '0; bus.reg_wen = 1'b0; bus.dmem_ren = 1'b0; bus.dmem_wen = 1'b0;
    bus.halt = 1'b0;
    st0 = mk_st(1'b0, 1'b0, 1'b0, TB_RESET_EPC);

    #1;
    check("reset pipe", dut_pipe, EXMEM_BUBBLE);
    check("reset status", dut_stat, st0);
    @(negedge CLK);
    nRST = 1'b1;

    // Basic capture, one cycle latency.
    p1 = mk_pipe(1'b1, 32'h20, 32'h10, 5'd5, 1'b1);
    drive(instr(32'h20, 32'h10, 5'd5, 1'b1), p1, st0);

    // Three stalled cycles with changing inputs: everything holds.
    v = instr(32'h30, 32'hdead_beef, 5'd7, 1'b0); v.en = 1'b0; v.halt = 1'b1;
    drive(v, p1, st0);
    v = instr(32'h34, 32'h0bad_f00d, 5'd8, 1'b1); v.en = 1'b0; v.wen = 1'b1; v.chk = 1'b1; v.over = 1'b1;
    drive(v, p1, st0);
    v = instr(32'h38, 32'h1111_2222, 5'd9, 1'b1); v.en = 1'b0; v.flush = 1'b1;
    drive(v, p1, st0);

    // Store with negative result and data.
    v = instr(32'h24, 32'hffff_fff0, 5'd0, 1'b0); v.neg = 1'b1; v.sd = 32'h1234_5678; v.wen = 1'b1;
    ep = mk_pipe(1'b1, 32'h24, 32'hffff_fff0, 5'd0, 1'b0);
    ep.neg = 1'b1; ep.store_data = 32'h1234_5678; ep.dmem_wen = 1'b1;
    drive(v, ep, st0);

    // Invalid slot: data captured, control bits masked.
    v = instr(32'h28, 32'h55, 5'd4, 1'b1); v.valid = 1'b0; v.ren = 1'b1; v.zero = 1'b1;
    ep = mk_pipe(1'b0, 32'h28, 32'h55, 5'd4, 1'b0); ep.zero = 1'b1;
    drive(v, ep, st0);

    // Flush beats overflow: bubble, no trap.
    v = instr(32'h2c, 32'h8000_0000, 5'd6, 1'b1); v.flush = 1'b1; v.chk = 1'b1; v.over = 1'b1;
    drive(v, EXMEM_BUBBLE, st0);

    // Signed overflow.
    v = instr(32'h40, 32'h8000_0000, 5'd3, 1'b1); v.chk = 1'b1; v.over = 1'b1;
`ifdef OVERFLOW_TRAP_EN
    p8 = mk_pipe(1'b1, 32'h40, 32'h8000_0000, 5'd3, 1'b0);
    drive(v, p8, mk_st(1'b1, 1'b1, 1'b0, 32'h40));
    v = instr(32'h44, 32'h1, 5'd8, 1'b1); v.en = 1'b0;
    drive(v, p8, mk_st(1'b0, 1'b1, 1'b0, 32'h40));
    v = instr(32'h44, 32'h1, 5'd8, 1'b1);
    drive(v, EXMEM_BUBBLE, mk_st(1'b0, 1'b1, 1'b0, 32'h40));
    v.exc_ack = 1'b1;
    drive(v, EXMEM_BUBBLE, mk_st(1'b0, 1'b0, 1'b0, 32'h40));
`else
    p8 = mk_pipe(1'b1, 32'h40, 32'h8000_0000, 5'd3, 1'b1);
    drive(v, p8, st0);
    v = instr(32'h44, 32'h1, 5'd8, 1'b1); v.exc_ack = 1'b1;
    drive(v, mk_pipe(1'b1, 32'h44, 32'h1, 5'd8, 1'b1), st0);
`endif

    // Overflow on an instruction that does not trap commits normally.
    v = instr(32'h4c, 32'h7fff_ffff, 5'd9, 1'b1); v.over = 1'b1;
    drive(v, mk_pipe(1'b1, 32'h4c, 32'h7fff_ffff, 5'd9, 1'b1), mk_st(1'b0, 1'b0, 1'b0, EPC_AFTER));

    // Halt reaches MEM, then everything is a bubble.
    v = instr(32'h50, 32'h0, 5'd0, 1'b0); v.halt = 1'b1;
    ep = mk_pipe(1'b1, 32'h50, 32'h0, 5'd0, 1'b0); ep.halt = 1'b1;
    drive(v, ep, mk_st(1'b0, 1'b0, 1'b1, EPC_AFTER));
    v = instr(32'h54, 32'h1, 5'd10, 1'b1);
    drive(v, EXMEM_BUBBLE, mk_st(1'b0, 1'b0, 1'b1, EPC_AFTER));
    v.exc_ack = 1'b1; v.chk = 1'b1; v.over = 1'b1;
    drive(v, EXMEM_BUBBLE, mk_st(1'b0, 1'b0, 1'b1, EPC_AFTER));
    v.en = 1'b0;
    drive(v, EXMEM_BUBBLE, mk_st(1'b0, 1'b0, 1'b1, EPC_AFTER));

    reset_pulse("reset halted");
    v = instr(32'h60, 32'h99, 5'd31, 1'b1); v.ren = 1'b1;
    ep = mk_pipe(1'b1, 32'h60, 32'h99, 5'd31, 1'b1); ep.dmem_ren = 1'b1;
    drive(v, ep, st0);

`ifdef OVERFLOW_TRAP_EN
    // Reset while in TRAP with a stall.
    v = instr(32'h70, 32'h8000_0000, 5'd2, 1'b1); v.chk = 1'b1; v.over = 1'b1;
    ep = mk_pipe(1'b1, 32'h70, 32'h8000_0000, 5'd2, 1'b0);
    drive(v, ep, mk_st(1'b1, 1'b1, 1'b0, 32'h70));
    v.en = 1'b0;
    drive(v, ep, mk_st(1'b0, 1'b1, 1'b0, 32'h70));
    reset_pulse("reset trap");
    drive(instr(32'h74, 32'h3, 5'd1, 1'b1), mk_pipe(1'b1, 32'h74, 32'h3, 5'd1, 1'b1), st0);
`endif

    @(negedge CLK);
    @(negedge CLK);
    check("scoreboard drained", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
